// File: rtl/spi_rect_fill.sv
// SPI display rectangle fill: sends the CASET/PASET/RAMWR window header, then
// streams one RGB565 colour over every pixel of the window.
module spi_rect_fill #(
    parameter int         CW        = 9,
    parameter int         HALF      = 1,
    parameter logic [7:0] CMD_CASET = 8'h2A,
    parameter logic [7:0] CMD_PASET = 8'h2B,
    parameter logic [7:0] CMD_RAMWR = 8'h2C
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic [CW-1:0] i_x1,
    input  logic [CW-1:0] i_x2,
    input  logic [CW-1:0] i_y1,
    input  logic [CW-1:0] i_y2,
    input  logic [15:0]   i_color,
    output logic          o_sclk,
    output logic          o_mosi,
    output logic          o_dc,
    output logic          o_cs,
    output logic          o_busy,
    output logic          o_done
);

    localparam int NW  = 2 * CW + 1;
    localparam int HCW = $clog2(2 * HALF);
    localparam logic [HCW-1:0] HC_LAST = HCW'(2 * HALF - 1);
    localparam logic [HCW-1:0] HC_HIGH = HCW'(HALF);

    typedef enum logic [2:0] {IDLE, LATCH, HDR, PIX, FIN} state_t;

    state_t r_state;
    state_t w_next;

    logic [CW-1:0]  r_x1, r_x2, r_y1, r_y2;
    logic [CW-1:0]  r_xa, r_xb, r_ya, r_yb;
    logic [15:0]    r_color;
    logic [NW-1:0]  r_n;
    logic [HCW-1:0] r_halfCnt;
    logic [2:0]     r_bitCnt;
    logic [3:0]     r_byteIdx;
    logic [NW-1:0]  r_pixCnt;
    logic           r_pixLo;

    logic [CW-1:0]  w_xa, w_xb, w_ya, w_yb;
    logic [CW:0]    w_wSpan, w_hSpan;
    logic [NW-1:0]  w_n;
    logic [15:0]    w_xa16, w_xb16, w_ya16, w_yb16;
    logic           w_byteEnd, w_hdrLast, w_pixLast, w_active;
    logic [7:0]     w_byte;
    logic           w_dc;

    assign w_xa    = (r_x1 <= r_x2) ? r_x1 : r_x2;
    assign w_xb    = (r_x1 <= r_x2) ? r_x2 : r_x1;
    assign w_ya    = (r_y1 <= r_y2) ? r_y1 : r_y2;
    assign w_yb    = (r_y1 <= r_y2) ? r_y2 : r_y1;
    assign w_wSpan = (CW+1)'(w_xb) - (CW+1)'(w_xa) + (CW+1)'(1);
    assign w_hSpan = (CW+1)'(w_yb) - (CW+1)'(w_ya) + (CW+1)'(1);
    assign w_n     = NW'(w_wSpan) * NW'(w_hSpan);

    assign w_xa16 = 16'(r_xa);
    assign w_xb16 = 16'(r_xb);
    assign w_ya16 = 16'(r_ya);
    assign w_yb16 = 16'(r_yb);

    assign w_byteEnd = (r_halfCnt == HC_LAST) && (r_bitCnt == 3'd7);
    assign w_hdrLast = (r_byteIdx == 4'd10);
    assign w_pixLast = r_pixLo && (r_pixCnt == r_n - NW'(1));
    assign w_active  = (r_state == HDR) || (r_state == PIX);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_start) w_next = LATCH;
            LATCH:   w_next = HDR;
            HDR:     if (w_byteEnd && w_hdrLast) w_next = PIX;
            PIX:     if (w_byteEnd && w_pixLast) w_next = FIN;
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Byte currently on the wire, chosen by header index or pixel half.
    always_comb begin
        w_byte = 8'h00;
        w_dc   = 1'b1;
        if (r_state == PIX) begin
            w_byte = r_pixLo ? r_color[7:0] : r_color[15:8];
        end else begin
            case (r_byteIdx)
                4'd0:    begin w_byte = CMD_CASET; w_dc = 1'b0; end
                4'd1:    w_byte = w_xa16[15:8];
                4'd2:    w_byte = w_xa16[7:0];
                4'd3:    w_byte = w_xb16[15:8];
                4'd4:    w_byte = w_xb16[7:0];
                4'd5:    begin w_byte = CMD_PASET; w_dc = 1'b0; end
                4'd6:    w_byte = w_ya16[15:8];
                4'd7:    w_byte = w_ya16[7:0];
                4'd8:    w_byte = w_yb16[15:8];
                4'd9:    w_byte = w_yb16[7:0];
                default: begin w_byte = CMD_RAMWR; w_dc = 1'b0; end
            endcase
        end
    end

    assign o_cs   = ~w_active;
    assign o_sclk = w_active && (r_halfCnt >= HC_HIGH);
    assign o_mosi = w_active && w_byte[3'd7 - r_bitCnt];
    assign o_dc   = w_active && w_dc;
    assign o_busy = (r_state != IDLE);
    assign o_done = (r_state == FIN);

    // Counters restart in LATCH so each fill begins a fresh header.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_x1      <= '0;
            r_x2      <= '0;
            r_y1      <= '0;
            r_y2      <= '0;
            r_color   <= '0;
            r_xa      <= '0;
            r_xb      <= '0;
            r_ya      <= '0;
            r_yb      <= '0;
            r_n       <= '0;
            r_halfCnt <= '0;
            r_bitCnt  <= '0;
            r_byteIdx <= '0;
            r_pixCnt  <= '0;
            r_pixLo   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_x1    <= i_x1;
                        r_x2    <= i_x2;
                        r_y1    <= i_y1;
                        r_y2    <= i_y2;
                        r_color <= i_color;
                    end
                end
                LATCH: begin
                    r_xa      <= w_xa;
                    r_xb      <= w_xb;
                    r_ya      <= w_ya;
                    r_yb      <= w_yb;
                    r_n       <= w_n;
                    r_halfCnt <= '0;
                    r_bitCnt  <= '0;
                    r_byteIdx <= '0;
                    r_pixCnt  <= '0;
                    r_pixLo   <= 1'b0;
                end
                HDR, PIX: begin
                    if (r_halfCnt == HC_LAST) begin
                        r_halfCnt <= '0;
                        r_bitCnt  <= r_bitCnt + 3'd1;
                    end else begin
                        r_halfCnt <= r_halfCnt + HCW'(1);
                    end
                    if (w_byteEnd) begin
                        if (r_state == HDR) begin
                            r_byteIdx <= r_byteIdx + 4'd1;
                        end else begin
                            r_pixLo <= ~r_pixLo;
                            if (r_pixLo) r_pixCnt <= r_pixCnt + NW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_rect_fill.sv
// Scoreboard bench for spi_rect_fill: stimulus pushes expected {dc,byte} and
// done cycles, monitors rebuild bytes from the SPI lines and compare.
module tb_spi_rect_fill;

    localparam int CW = 9;

    logic          clk = 1'b0;
    logic          rstN = 1'b0;
    logic          startA = 1'b0;
    logic          startB = 1'b0;
    logic [CW-1:0] x1 = '0, x2 = '0, y1 = '0, y2 = '0;
    logic [15:0]   color = '0;

    logic sclkA, mosiA, dcA, csA, busyA, doneA;
    logic sclkB, mosiB, dcB, csB, busyB, doneB;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [8:0] qA[$];
    logic [8:0] qB[$];
    int         qDoneA[$];
    int         qDoneB[$];
    int         expFirstB = -1;

    spi_rect_fill #(.CW(CW), .HALF(1)) dutA (
        .i_clk(clk), .i_rst_n(rstN), .i_start(startA),
        .i_x1(x1), .i_x2(x2), .i_y1(y1), .i_y2(y2), .i_color(color),
        .o_sclk(sclkA), .o_mosi(mosiA), .o_dc(dcA), .o_cs(csA),
        .o_busy(busyA), .o_done(doneA)
    );

    spi_rect_fill #(.CW(CW), .HALF(3)) dutB (
        .i_clk(clk), .i_rst_n(rstN), .i_start(startB),
        .i_x1(x1), .i_x2(x2), .i_y1(y1), .i_y2(y2), .i_color(color),
        .o_sclk(sclkB), .o_mosi(mosiB), .o_dc(dcB), .o_cs(csB),
        .o_busy(busyB), .o_done(doneB)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic pushExp(input bit toB, input logic [8:0] v);
        if (toB) qB.push_back(v);
        else     qA.push_back(v);
    endtask

    // Called at a negedge; issues a one-cycle start and queues the expected response.
    task automatic applyStimulus(input bit toB, input int ax1, input int ax2, input int ay1,
                                 input int ay2, input logic [15:0] col, input bit relRst);
        int xa, xb, ya, yb, n, half;
        logic [15:0] w;
        xa = (ax1 < ax2) ? ax1 : ax2;
        xb = (ax1 < ax2) ? ax2 : ax1;
        ya = (ay1 < ay2) ? ay1 : ay2;
        yb = (ay1 < ay2) ? ay2 : ay1;
        n = (xb - xa + 1) * (yb - ya + 1);
        half = toB ? 3 : 1;
        x1 = CW'(ax1);
        x2 = CW'(ax2);
        y1 = CW'(ay1);
        y2 = CW'(ay2);
        color = col;
        if (relRst) rstN = 1'b1;
        if (toB) startB = 1'b1;
        else     startA = 1'b1;
        pushExp(toB, {1'b0, 8'h2A});
        w = 16'(xa); pushExp(toB, {1'b1, w[15:8]}); pushExp(toB, {1'b1, w[7:0]});
        w = 16'(xb); pushExp(toB, {1'b1, w[15:8]}); pushExp(toB, {1'b1, w[7:0]});
        pushExp(toB, {1'b0, 8'h2B});
        w = 16'(ya); pushExp(toB, {1'b1, w[15:8]}); pushExp(toB, {1'b1, w[7:0]});
        w = 16'(yb); pushExp(toB, {1'b1, w[15:8]}); pushExp(toB, {1'b1, w[7:0]});
        pushExp(toB, {1'b0, 8'h2C});
        for (int i = 0; i < n; i++) begin
            pushExp(toB, {1'b1, col[15:8]});
            pushExp(toB, {1'b1, col[7:0]});
        end
        if (toB) begin
            qDoneB.push_back(cyc + 2 + 16 * half * (11 + 2 * n));
            expFirstB = cyc + 2 + half;
        end else begin
            qDoneA.push_back(cyc + 2 + 16 * half * (11 + 2 * n));
        end
        @(negedge clk);
        startA = 1'b0;
        startB = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while ((qA.size() != 0 || qB.size() != 0 || qDoneA.size() != 0 || qDoneB.size() != 0)
               && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("[TB] FAIL fill timeout: %0d bytes and %0d dones still pending",
                     qA.size() + qB.size(), qDoneA.size() + qDoneB.size());
            qA.delete(); qB.delete(); qDoneA.delete(); qDoneB.delete();
        end
        repeat (2) @(negedge clk);
        checkOutput("idle busy {A,B}", {busyA, busyB}, 2'b00);
    endtask

    // Monitor for the HALF=1 instance.
    logic [7:0] shA;
    int bitsA = 0, csRisesA = 0;
    logic prevSclkA = 1'b0, prevCsA = 1'b1;
    always @(negedge clk) begin
        if (!rstN) begin
            bitsA = 0; prevSclkA = 1'b0; prevCsA = 1'b1; csRisesA = 0;
        end else begin
            if (csA && !prevCsA) csRisesA++;
            if (sclkA && !prevSclkA) begin
                shA = {shA[6:0], mosiA};
                bitsA++;
                if (bitsA == 8) begin
                    bitsA = 0;
                    if (qA.size() == 0) begin
                        checks++; errors++;
                        $display("[TB] FAIL A unexpected byte: got %h expected none", {dcA, shA});
                    end else begin
                        checkOutput("A byte {cs,dc,data}", {csA, dcA, shA}, {1'b0, qA.pop_front()});
                    end
                end
            end
            if (doneA) begin
                if (qDoneA.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL A unexpected done: got pulse expected none");
                end else begin
                    checkOutput("A done cycle", cyc, qDoneA.pop_front());
                    checkOutput("A cs rises per fill", csRisesA, 1);
                    checkOutput("A dc in FIN", dcA, 1'b0);
                end
                csRisesA = 0;
            end
            prevSclkA = sclkA;
            prevCsA = csA;
        end
    end

    // Monitor for the HALF=3 instance, also checking SCLK period and MOSI setup.
    logic [7:0] shB;
    int bitsB = 0, lastRiseB = -1;
    logic prevSclkB = 1'b0, prevMosiB = 1'b0;
    always @(negedge clk) begin
        if (!rstN) begin
            bitsB = 0; prevSclkB = 1'b0; prevMosiB = 1'b0; lastRiseB = -1;
        end else begin
            if (sclkB && !prevSclkB) begin
                checkOutput("B mosi stable at rise", mosiB, prevMosiB);
                if (lastRiseB >= 0) checkOutput("B sclk period", cyc - lastRiseB, 6);
                if (expFirstB >= 0) begin
                    checkOutput("B first sclk rise", cyc, expFirstB);
                    expFirstB = -1;
                end
                lastRiseB = cyc;
                shB = {shB[6:0], mosiB};
                bitsB++;
                if (bitsB == 8) begin
                    bitsB = 0;
                    if (qB.size() == 0) begin
                        checks++; errors++;
                        $display("[TB] FAIL B unexpected byte: got %h expected none", {dcB, shB});
                    end else begin
                        checkOutput("B byte {cs,dc,data}", {csB, dcB, shB}, {1'b0, qB.pop_front()});
                    end
                end
            end
            if (doneB) begin
                if (qDoneB.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL B unexpected done: got pulse expected none");
                end else begin
                    checkOutput("B done cycle", cyc, qDoneB.pop_front());
                end
                lastRiseB = -1;
            end
            prevSclkB = sclkB;
            prevMosiB = mosiB;
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("A reset {sclk,mosi,dc,cs,busy,done}",
                    {sclkA, mosiA, dcA, csA, busyA, doneA}, 6'b000100);
        checkOutput("B reset {sclk,mosi,dc,cs,busy,done}",
                    {sclkB, mosiB, dcB, csB, busyB, doneB}, 6'b000100);
        rstN = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] degenerate 1x1 window");
        applyStimulus(0, 5, 5, 7, 7, 16'hF800, 0);
        checkOutput("A busy in LATCH", {busyA, csA}, 2'b11);
        waitIdle(1000);

        $display("[TB] 1x10 column, start pulsed mid-pixel");
        applyStimulus(0, 100, 100, 10, 19, 16'hFFFF, 0);
        repeat (200) @(negedge clk);
        x1 = 9'd1; x2 = 9'd2; y1 = 9'd3; y2 = 9'd4; color = 16'h1234;
        startA = 1'b1;
        @(negedge clk);
        startA = 1'b0;
        waitIdle(2000);

        $display("[TB] swapped bounds 11x11");
        applyStimulus(0, 20, 10, 300, 290, 16'h07E0, 0);
        waitIdle(6000);

        $display("[TB] wide strip 240x4");
        applyStimulus(0, 0, 239, 0, 3, 16'h001F, 0);
        waitIdle(40000);

        $display("[TB] reset mid-pixel then restart on release edge");
        applyStimulus(0, 0, 9, 0, 9, 16'hABCD, 0);
        repeat (250) @(negedge clk);
        #1 rstN = 1'b0;
        #1 checkOutput("A async reset {cs,sclk,done,busy}", {csA, sclkA, doneA, busyA}, 4'b1000);
        qA.delete();
        qDoneA.delete();
        repeat (3) @(negedge clk);
        applyStimulus(0, 3, 3, 4, 4, 16'h1234, 1);
        waitIdle(1000);

        $display("[TB] HALF=3 degenerate window");
        applyStimulus(1, 5, 5, 7, 7, 16'hA55A, 0);
        waitIdle(2000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_rect_fill.md
SPI_RECT_FILL -- requirements
Module: spi_rect_fill

Interface
REQ-001 Parameter CW, default 9: coordinate width in bits, legal range 1..16.
REQ-002 Parameter HALF, default 1: SCLK half-period in i_clk cycles, minimum 1.
REQ-003 Parameter CMD_CASET, default 8'h2A: column-address command byte.
REQ-004 Parameter CMD_PASET, default 8'h2B: page-address command byte.
REQ-005 Parameter CMD_RAMWR, default 8'h2C: memory-write command byte.
REQ-006 i_clk  in  1  sole clock; all logic on its rising edge.
REQ-007 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-008 i_start  in  1  one-cycle request; sampled only in IDLE.
REQ-009 i_x1, i_x2  in  CW  column bounds, inclusive.
REQ-010 i_y1, i_y2  in  CW  page bounds, inclusive.
REQ-011 i_color  in  16  RGB565 fill colour.
REQ-012 o_sclk  out  1  SPI clock, mode 0, idle low.
REQ-013 o_mosi  out  1  serial data, MSB first.
REQ-014 o_dc  out  1  0 = command byte, 1 = data byte.
REQ-015 o_cs  out  1  chip select, active-low.
REQ-016 o_busy  out  1  high while a fill is in progress.
REQ-017 o_done  out  1  one-cycle completion pulse.

Function
REQ-018 States SHALL be IDLE, LATCH, HDR, PIX, FIN.
REQ-019 IDLE: i_start=1 -> LATCH. All inputs SHALL be registered in that same cycle; later input changes have no effect on the running fill.
REQ-020 LATCH (1 cycle): swap the bounds so that xa=min(x1,x2), xb=max(x1,x2), ya=min(y1,y2), yb=max(y1,y2).
REQ-021 LATCH: pixel count N=(xb-xa+1)*(yb-ya+1) SHALL be computed at 2*CW+1 bits, so that no overflow is possible; next state HDR.
REQ-022 HDR SHALL send 11 bytes in this order: CMD_CASET, xa[15:8], xa[7:0], xb[15:8], xb[7:0], CMD_PASET, ya hi, ya lo, yb hi, yb lo, CMD_RAMWR.
REQ-023 Coordinates SHALL be zero-extended to 16 bits before being split into high and low bytes.
REQ-024 o_dc SHALL be 0 for the three command bytes and 1 for all other bytes; o_dc changes only between bytes.
REQ-025 PIX SHALL send N pixels, each as i_color[15:8] then i_color[7:0], with o_dc=1; total 2N data bytes. After the last byte -> FIN.
REQ-026 Bit timing: each bit lasts 2*HALF cycles. o_mosi is set while o_sclk is low; o_sclk is low for HALF cycles, then high for HALF cycles.
REQ-027 Bytes SHALL be sent back-to-back with no idle gap; each byte takes 16*HALF cycles.
REQ-028 o_cs SHALL be 0 from the first HDR bit to the end of the last pixel bit, and 1 at all other times, including LATCH and FIN.
REQ-029 FIN (1 cycle): o_done=1, o_dc=0, next state IDLE.
REQ-030 o_busy SHALL be 1 in LATCH, HDR, PIX and FIN, and 0 in IDLE; i_start is ignored while o_busy=1.
REQ-031 The byte index (0..10) and the pixel-byte counter SHALL be cleared on entry to HDR, so back-to-back fills are independent.
REQ-032 Degenerate window (xa=xb, ya=yb) SHALL send exactly one pixel.
REQ-033 Latency: first o_sclk rising edge at cycle 2+HALF after the i_start cycle; o_done at cycle 2+16*HALF*(11+2N) after the i_start cycle.

Reset
REQ-034 With i_rst_n=0 the block SHALL go to IDLE asynchronously, with o_sclk=0, o_mosi=0, o_dc=0, o_cs=1, o_busy=0, o_done=0.
REQ-035 Reset mid-fill SHALL abort the fill with no o_done pulse; counters are cleared; the next i_start begins a fresh header.
REQ-036 Reset release SHALL take effect on the first rising edge of i_clk with i_rst_n=1; i_start in that cycle is accepted.

Verification
REQ-037 CW=9, HALF=1, x1=x2=5, y1=y2=7, colour 16'hF800 -> bytes 2A 00 05 00 05 2B 00 07 00 07 2C F8 00; dc pattern 0,1,1,1,1,0,1,1,1,1,0,1,1; one o_done pulse.
REQ-038 x1=x2=100, y1=10, y2=19, colour FFFF -> header x 0064/0064, y 000A/0013; exactly 20 pixel bytes of FF.
REQ-039 x1=20, x2=10, y1=300, y2=290 -> x sent as 000A/0014, y as 0122/012C; 11*11=121 pixels.
REQ-040 x 0..239, y 0..319 -> 76800 pixels (153600 data bytes); o_cs stays continuously low; o_done at the cycle given in REQ-033.
REQ-041 i_start pulsed during PIX -> ignored, byte count unchanged. Reset asserted mid-pixel -> o_cs=1 and o_sclk=0 immediately, and no o_done.
REQ-042 HALF=3 -> o_sclk period 6 cycles; 48 cycles per byte; o_mosi is stable across every o_sclk rising edge.
